shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of the shift register.
REQ-002 SHALL have parameter AMT_W, default 3, width of the shift amount; AMT_W = clog2(WIDTH).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to run one shift operation.
REQ-006 SHALL have port data_in  input  WIDTH  operand loaded at accept.
REQ-007 SHALL have port amount  input  AMT_W  number of single-bit right shifts, 0..WIDTH-1.
REQ-008 SHALL have port asr  input  1  1 = arithmetic right shift (replicate MSB), 0 = logical (shift in 0).
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port q  output  WIDTH  shift register contents.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-013 SHALL accept start only in IDLE; at the accepting edge, load data_in into q, and latch amount into a down-counter and asr into a mode register.
REQ-014 SHALL transition IDLE->SHIFT on accept with amount != 0, and IDLE->DONE on accept with amount == 0.
REQ-015 SHALL perform exactly one right shift per cycle in SHIFT and decrement the counter each cycle; at the edge where the counter is 1, shift and go to DONE.
REQ-016 SHALL fill the vacated MSB with q[WIDTH-1] when the latched mode is 1, and with 0 otherwise; changes to asr or amount after accept have no effect.
REQ-017 SHALL assert done only in DONE, for exactly one cycle, then return to IDLE.
REQ-018 SHALL meet this timing for start sampled high in cycle 0: busy high in cycles 1..amount+1, done high in cycle amount+1, IDLE in cycle amount+2.
REQ-019 SHALL ignore start while busy: no reload, no restart, no error.
REQ-020 SHALL accept a start present in the first IDLE cycle after DONE, so back-to-back operations have a one-cycle gap.
REQ-021 SHALL hold q stable from the done cycle until the next accepted start.

Reset
REQ-022 SHALL, with reset high at a posedge, force state IDLE, q=0, counter=0, mode=0, busy=0, done=0.
REQ-023 SHALL give reset priority over start and over any in-flight operation; an aborted operation produces no done pulse.
REQ-024 SHALL be able to accept a start in the first cycle after reset deasserts.

Structure
REQ-025 SHALL take the state enumeration and the WIDTH/AMT_W defaults from shared package shift_seq_pkg.
REQ-026 SHALL place the register in sub-module shift_datapath: WIDTH-bit register with load, shift-enable and fill-bit inputs and synchronous active-high reset.
REQ-027 SHALL keep the FSM and counter in shift_sequencer, which drives load, shift-enable and fill bit to shift_datapath.

Verification
REQ-028 Bench SHALL cover: data_in=0xB4, amount=3, asr=1 -> done in cycle 4, q=0xF6; same stimulus with asr=0 -> q=0x16.
REQ-029 Bench SHALL cover: data_in=0x5A, amount=0 -> done in cycle 1, q=0x5A, busy high for that cycle only.
REQ-030 Bench SHALL cover: data_in=0x80, amount=7, asr=1 -> q=0xFF at done in cycle 8; asr=0 -> q=0x01.
REQ-031 Bench SHALL cover: start with data_in=0x33 held high throughout a running 0xB4/amount=3 op -> first result unaffected, 0x33 accepted in the IDLE cycle after done.
REQ-032 Bench SHALL cover: reset asserted in cycle 2 of an amount=5 op -> next cycle q=0, busy=0, and no done pulse appears.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared types and defaults for the shift sequencer.
// State codes are plain constants so legacy code can compare against them.
package shift_seq_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int AMT_W_DEF = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/shift_datapath.sv
// Shift register with load, shift-enable and MSB fill bit.
// Load has priority over shift.
module shift_datapath
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic             fill,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift_en) begin
      q <= {fill, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle right shifter: one bit per cycle, done pulse on completion.
// FSM and down-counter live here; the register is in shift_datapath.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = AMT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] amount,
  input  logic             asr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q
);

  state_t           state;
  logic [AMT_W-1:0] cnt;
  logic             mode;
  logic             accept;
  logic             shift_en;
  logic             fill;

  assign accept   = (state == ST_IDLE) && start;
  assign shift_en = (state == ST_SHIFT);
  assign fill     = mode & q[WIDTH-1];
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      mode  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cnt   <= amount;
            mode  <= asr;
            state <= (amount == '0) ? ST_DONE : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          cnt <= cnt - AMT_W'(1);
          if (cnt == AMT_W'(1)) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  shift_datapath #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .shift_en(shift_en),
    .fill    (fill),
    .d       (data_in),
    .q       (q)
  );

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer.
// Stimulus pushes expected results; a monitor pops them on each done pulse.
module tb_shift_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] data_in;
  logic [2:0] amount;
  logic       asr;
  logic       busy;
  logic       done;
  logic [7:0] q;

  typedef struct {
    logic [7:0] q;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   checks;
  int   errors;

  shift_sequencer #(
    .WIDTH(8),
    .AMT_W(3)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .data_in(data_in),
    .amount (amount),
    .asr    (asr),
    .busy   (busy),
    .done   (done),
    .q      (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      exp_t e;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1, expected none (cycle %0d)",
                 cyc);
      end else begin
        e = sb.pop_front();
        chk("done_q", int'(q), int'(e.q));
        chk("done_cycle", cyc, e.cyc);
        chk("busy_at_done", int'(busy), 1);
      end
    end
  end

  task automatic run_op(input logic [7:0] d, input logic [2:0] a,
                        input logic m, input logic [7:0] exp_q);
    exp_t e;
    @(negedge clk);
    start   = 1'b1;
    data_in = d;
    amount  = a;
    asr     = m;
    e.q     = exp_q;
    e.cyc   = cyc + int'(a) + 1;
    sb.push_back(e);
    @(negedge clk);
    start   = 1'b0;
    data_in = 8'h00;
    amount  = 3'd0;
    asr     = ~m;
    chk("busy_cycle1", int'(busy), 1);
    repeat (int'(a)) @(negedge clk);
    @(negedge clk);
    chk("busy_after_done", int'(busy), 0);
  endtask

  initial begin
    exp_t e;
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    start   = 1'b0;
    data_in = 8'h00;
    amount  = 3'd0;
    asr     = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_q", int'(q), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    reset = 1'b0;

    run_op(8'hB4, 3'd3, 1'b1, 8'hF6);
    run_op(8'hB4, 3'd3, 1'b0, 8'h16);
    run_op(8'h5A, 3'd0, 1'b0, 8'h5A);
    run_op(8'h80, 3'd7, 1'b1, 8'hFF);
    run_op(8'h80, 3'd7, 1'b0, 8'h01);

    // start held high through a running op, operands changed mid-flight
    @(negedge clk);
    start   = 1'b1;
    data_in = 8'hB4;
    amount  = 3'd3;
    asr     = 1'b1;
    e.q     = 8'hF6;
    e.cyc   = cyc + 4;
    sb.push_back(e);
    @(negedge clk);
    data_in = 8'h33;
    amount  = 3'd1;
    asr     = 1'b0;
    e.q     = 8'h19;
    e.cyc   = cyc + 6;
    sb.push_back(e);
    repeat (3) @(negedge clk);
    chk("hold_q_stable_at_done", int'(q), 8'hF6);
    @(negedge clk);
    chk("hold_idle_gap", int'(busy), 0);
    @(negedge clk);
    start = 1'b0;
    chk("hold_second_accepted", int'(busy), 1);
    chk("hold_second_loaded", int'(q), 8'h33);
    repeat (3) @(negedge clk);
    chk("hold_q_stable_after", int'(q), 8'h19);

    // reset during an amount=5 op aborts it with no done pulse
    @(negedge clk);
    start   = 1'b1;
    data_in = 8'hFF;
    amount  = 3'd5;
    asr     = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_q", int'(q), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    reset   = 1'b0;
    start   = 1'b1;
    data_in = 8'hC3;
    amount  = 3'd2;
    asr     = 1'b1;
    e.q     = 8'hF0;
    e.cyc   = cyc + 3;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("post_reset_accept", int'(busy), 1);
    repeat (8) @(negedge clk);

    for (int i = 0; i < 50; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
